// File: rtl/ct_f_spsram_gen.sv
// Generic single-port SRAM model with per-segment write enables, optional output register
// and a hardware clear engine that zeroes the array after reset or on request.
module ct_f_spsram_gen #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 59,
  parameter int SEG_W    = 29,
  parameter int OUT_REG  = 0,
  parameter int INIT_CLR = 1
) (
  input  logic              CLK,
  input  logic              cpurst_b,
  input  logic [ADDR_W-1:0] A,
  input  logic              CEN,
  input  logic              GWEN,
  input  logic [DATA_W-1:0] WEN,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  input  logic              CLR_REQ,
  output logic              INIT_DONE
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] q_q, q_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              access;
  logic              wr_en;
  logic              clr_we;
  logic              clr_last;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] seg_mask;

  // Each data bit follows the mask bit at the bottom of its segment.
  always_comb begin
    seg_mask = '0;
    for (int b = 0; b < DATA_W; b++) begin
      seg_mask[b] = ~WEN[(b / SEG_W) * SEG_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    addr_hold_d = addr_hold_q;
    access      = 1'b0;
    wr_en       = 1'b0;
    clr_we      = 1'b0;
    clr_last    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (&clr_cnt_q) begin
          clr_last  = 1'b1;
          state_d   = READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY: begin
        access = ~CEN;
        wr_en  = ~CEN & ~GWEN;
        if (access) begin
          addr_hold_d = A;
        end
        if (CLR_REQ) begin
          state_d = CLEAR;
        end
      end
      default: state_d = READY;
    endcase
  end

  // An idle cycle re-reads the held address, so Q keeps the last word read.
  always_comb begin
    rd_addr = access ? A : addr_hold_q;
    rd_word = mem[rd_addr];
    wr_word = (D & seg_mask) | (rd_word & ~seg_mask);
    q_d     = '0;
    if (state_q == READY) begin
      q_d = wr_en ? wr_word : rd_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      mem[A] <= wr_word;
    end
  end

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= (INIT_CLR != 0) ? CLEAR : READY;
      clr_cnt_q   <= '0;
      addr_hold_q <= '0;
      q_q         <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      addr_hold_q <= addr_hold_d;
      q_q         <= q_d;
    end
  end

  assign INIT_DONE = (state_q == READY);

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] q_pipe_q, q_pipe_d;
      logic              clr_end_q;

      always_comb begin
        q_pipe_d = q_q;
        if (state_q == CLEAR || clr_end_q) begin
          q_pipe_d = '0;
        end
      end

      always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
          q_pipe_q  <= '0;
          clr_end_q <= 1'b0;
        end else begin
          q_pipe_q  <= q_pipe_d;
          clr_end_q <= clr_last;
        end
      end

      assign Q = (state_q == CLEAR) ? '0 : q_pipe_q;
    end else begin : g_no_out_reg
      assign Q = (state_q == CLEAR) ? '0 : q_q;
    end
  endgenerate

endmodule

// File: tb/tb_ct_f_spsram_gen.sv
// Randomised and directed bench for ct_f_spsram_gen; two instances (OUT_REG 0 and 1)
// share the stimulus and are checked against a word-array reference model.
module tb_ct_f_spsram_gen;

  localparam int AW    = 8;
  localparam int DW    = 59;
  localparam int SW    = 29;
  localparam int DEPTH = 256;

  logic          CLK = 1'b0;
  logic          cpurst_b;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic          CLR_REQ;
  logic [DW-1:0] q0, q1;
  logic          done0, done1;

  ct_f_spsram_gen #(.OUT_REG(0)) u_dut0 (
    .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .Q(q0), .CLR_REQ(CLR_REQ), .INIT_DONE(done0)
  );

  ct_f_spsram_gen #(.OUT_REG(1)) u_dut1 (
    .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .Q(q1), .CLR_REQ(CLR_REQ), .INIT_DONE(done1)
  );

  always #5 CLK = ~CLK;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: plain word array plus the words expected on each output.
  logic [DW-1:0] mMem [DEPTH];
  bit            clearing;
  int            clrCnt;
  logic [DW-1:0] expQ0, expQ1;
  logic [AW-1:0] lastAddr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mergeWord(input logic [DW-1:0] oldW, input logic [DW-1:0] wen,
                                              input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = oldW;
    for (int k = 0; k * SW < DW; k++) begin
      if (wen[k * SW] == 1'b0) begin
        for (int b = k * SW; b < DW && b < (k + 1) * SW; b++) r[b] = d[b];
      end
    end
    return r;
  endfunction

  task automatic modelReset();
    clearing = 1'b1;
    clrCnt   = 0;
    expQ0    = '0;
    expQ1    = '0;
    lastAddr = '0;
  endtask

  task automatic modelEdge(input logic cen, input logic gwen, input logic [DW-1:0] wen,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic clr);
    if (clearing) begin
      mMem[clrCnt] = '0;
      clrCnt++;
      if (clrCnt == DEPTH) begin
        clearing = 1'b0;
        clrCnt   = 0;
      end
      expQ0 = '0;
      expQ1 = '0;
    end else begin
      expQ1 = expQ0;
      if (!cen) begin
        if (!gwen) mMem[a] = mergeWord(mMem[a], wen, d);
        lastAddr = a;
      end
      expQ0 = mMem[lastAddr];
      if (clr) clearing = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic cen, input logic gwen, input logic [DW-1:0] wen,
                               input logic [AW-1:0] a, input logic [DW-1:0] d, input logic clr);
    CEN = cen; GWEN = gwen; WEN = wen; A = a; D = d; CLR_REQ = clr;
    @(posedge CLK);
    modelEdge(cen, gwen, wen, a, d, clr);
    @(negedge CLK);
    checkOutput("initDone0", 64'(done0), 64'(!clearing));
    checkOutput("initDone1", 64'(done1), 64'(!clearing));
    checkOutput("q0", 64'(q0), clearing ? 64'd0 : 64'(expQ0));
    checkOutput("q1", 64'(q1), clearing ? 64'd0 : 64'(expQ1));
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b1, '1, '0, '0, 1'b0);
  endtask

  task automatic waitInit(input string tag);
    int cyc;
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 1000) begin
      idle();
      cyc++;
    end
    checkOutput(tag, 64'(cyc), 64'd256);
  endtask

  function automatic logic [DW-1:0] randWord();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  initial begin
    logic [DW-1:0] w [3];
    logic [DW-1:0] obs [5];
    cpurst_b = 1'b0;
    CEN = 1'b1; GWEN = 1'b1; WEN = '1; A = '0; D = '0; CLR_REQ = 1'b0;
    modelReset();
    repeat (3) @(negedge CLK);
    checkOutput("rstQ0", 64'(q0), 64'd0);
    checkOutput("rstQ1", 64'(q1), 64'd0);
    checkOutput("rstDone", 64'(done0), 64'd0);
    cpurst_b = 1'b1;
    waitInit("initLen");

    // Freshly cleared array reads back zero.
    applyStimulus(1'b0, 1'b1, '1, 8'h00, '0, 1'b0);
    checkOutput("rd00", 64'(q0), 64'd0);
    applyStimulus(1'b0, 1'b1, '1, 8'h80, '0, 1'b0);
    checkOutput("rd80", 64'(q0), 64'd0);
    applyStimulus(1'b0, 1'b1, '1, 8'hFF, '0, 1'b0);
    checkOutput("rdFF", 64'(q0), 64'd0);

    applyStimulus(1'b0, 1'b0, '0, 8'h12, '1, 1'b0);
    applyStimulus(1'b0, 1'b1, '1, 8'h12, '0, 1'b0);
    checkOutput("rd12ones", 64'(q0), 64'h07FF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("hold12", 64'(q0), 64'h07FF_FFFF_FFFF_FFFF);
    end

    // Only the middle segment is written; bit 58 is the narrow top segment.
    applyStimulus(1'b0, 1'b0, ~(59'd1 << 29), 8'h12, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, '1, 8'h12, '0, 1'b0);
    checkOutput("segWrite", 64'(q0), 64'h0400_0000_1FFF_FFFF);

    for (int i = 0; i < 3; i++) begin
      w[i] = randWord();
      applyStimulus(1'b0, 1'b0, '0, AW'(i + 1), w[i], 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) applyStimulus(1'b0, 1'b1, '1, AW'(i + 1), '0, 1'b0);
      else idle();
      obs[i] = q1;
    end
    checkOutput("pipe01", 64'(obs[1]), 64'(w[0]));
    checkOutput("pipe02", 64'(obs[2]), 64'(w[1]));
    checkOutput("pipe03", 64'(obs[3]), 64'(w[2]));

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), randWord(),
                    AW'($urandom_range(0, 15)), randWord(), 1'b0);
    end

    applyStimulus(1'b0, 1'b0, '0, 8'h05, randWord(), 1'b1);
    checkOutput("clrDrop", 64'(done0), 64'd0);
    waitInit("clrLen");
    applyStimulus(1'b0, 1'b1, '1, 8'h05, '0, 1'b0);
    checkOutput("rd05", 64'(q0), 64'd0);

    for (int i = 0; i < 100; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), randWord(),
                    AW'($urandom_range(0, 7)), randWord(), 1'b0);
    end

    // Reset in the middle of a clear restarts the full sweep.
    applyStimulus(1'b1, 1'b1, '1, '0, '0, 1'b1);
    repeat (100) idle();
    cpurst_b = 1'b0;
    #1;
    modelReset();
    checkOutput("midRstQ0", 64'(q0), 64'd0);
    checkOutput("midRstQ1", 64'(q1), 64'd0);
    checkOutput("midRstDone", 64'(done0), 64'd0);
    @(negedge CLK);
    cpurst_b = 1'b1;
    waitInit("reInitLen");

    for (int i = 0; i < 100; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), randWord(),
                    AW'($urandom_range(0, 15)), randWord(), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
